// File: rtl/stage_ex_mem_if.sv
// Bus between the ID/EX register, hazard unit, fetch redirect and the execute stage.
// master = surrounding pipeline, slave = stage_ex_mem.
interface stage_ex_mem_if #(
    parameter int unsigned XLEN = 32
);
    // Pipeline control
    logic            stall;
    logic            flush;

    // ID/EX payload
    logic [XLEN-1:0] in_A;
    logic [XLEN-1:0] in_B;
    logic [3:0]      in_control;
    logic            in_reg_write;
    logic            in_wed;
    logic            in_is_branch_instr;
    logic            in_is_jmp_instr;
    logic            in_is_jmpr_instr;
    logic            in_ALUSrc;
    logic [1:0]      in_Result_Src;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_pc_plus_4;
    logic [XLEN-1:0] in_immediate;
    logic [4:0]      in_rd;
    logic [2:0]      in_func3;

    // Forwarding
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [XLEN-1:0] mem_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;

    // Fetch redirect
    logic            pc_src;
    logic [XLEN-1:0] pc_target;

    // EX/MEM register
    logic [XLEN-1:0] o_alu_result;
    logic [XLEN-1:0] o_write_data;
    logic            o_reg_write;
    logic            o_wed;
    logic [1:0]      o_Result_Src;
    logic [XLEN-1:0] o_pc_plus_4;
    logic [4:0]      o_rd;
    logic [2:0]      o_func3;

    modport master (
        output stall, flush,
        output in_A, in_B, in_control, in_reg_write, in_wed,
        output in_is_branch_instr, in_is_jmp_instr, in_is_jmpr_instr,
        output in_ALUSrc, in_Result_Src, in_pc, in_pc_plus_4, in_immediate,
        output in_rd, in_func3,
        output fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
        input  pc_src, pc_target,
        input  o_alu_result, o_write_data, o_reg_write, o_wed,
        input  o_Result_Src, o_pc_plus_4, o_rd, o_func3
    );

    modport slave (
        input  stall, flush,
        input  in_A, in_B, in_control, in_reg_write, in_wed,
        input  in_is_branch_instr, in_is_jmp_instr, in_is_jmpr_instr,
        input  in_ALUSrc, in_Result_Src, in_pc, in_pc_plus_4, in_immediate,
        input  in_rd, in_func3,
        input  fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
        output pc_src, pc_target,
        output o_alu_result, o_write_data, o_reg_write, o_wed,
        output o_Result_Src, o_pc_plus_4, o_rd, o_func3
    );
endinterface

// File: rtl/stage_ex_mem.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution with fetch redirect,
// and the EX/MEM pipeline register.
module stage_ex_mem #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    stage_ex_mem_if.slave bus
);
    localparam int unsigned SHW = 5;

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [SHW-1:0]  shamt;
    logic            taken;

    // Forwarding muxes; 11 falls back to the ID/EX value
    always_comb begin
        fa = bus.in_A;
        case (bus.fwd_a_sel)
            2'b01:   fa = bus.mem_fwd_data;
            2'b10:   fa = bus.wb_fwd_data;
            default: fa = bus.in_A;
        endcase
    end

    always_comb begin
        fb = bus.in_B;
        case (bus.fwd_b_sel)
            2'b01:   fb = bus.mem_fwd_data;
            2'b10:   fb = bus.wb_fwd_data;
            default: fb = bus.in_B;
        endcase
    end

    assign op2   = bus.in_ALUSrc ? bus.in_immediate : fb;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        alu = '0;
        case (bus.in_control)
            4'b0000: alu = fa + op2;
            4'b0001: alu = fa - op2;
            4'b0010: alu = fa & op2;
            4'b0011: alu = fa | op2;
            4'b0100: alu = fa ^ op2;
            4'b0101: alu = fa << shamt;
            4'b0110: alu = fa >> shamt;
            4'b0111: alu = XLEN'($signed(fa) >>> shamt);
            4'b1000: alu = XLEN'($signed(fa) < $signed(op2));
            4'b1001: alu = XLEN'(fa < op2);
            4'b1010: alu = op2;
            default: alu = '0;
        endcase
    end

    // Branch condition always compares the two register operands
    always_comb begin
        taken = 1'b0;
        case (bus.in_func3)
            3'b000:  taken = (fa == fb);
            3'b001:  taken = (fa != fb);
            3'b100:  taken = ($signed(fa) <  $signed(fb));
            3'b101:  taken = ($signed(fa) >= $signed(fb));
            3'b110:  taken = (fa <  fb);
            3'b111:  taken = (fa >= fb);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum = fa + bus.in_immediate;

    always_comb begin
        target = bus.in_pc + bus.in_immediate;
        if (bus.in_is_jmpr_instr)
            target = jalr_sum & ~XLEN'(1);
    end

    // Redirect is suppressed while stalled so a held instruction redirects only once
    assign bus.pc_src    = !bus.stall & (bus.in_is_jmp_instr | bus.in_is_jmpr_instr |
                                         (bus.in_is_branch_instr & taken));
    assign bus.pc_target = target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_alu_result <= '0;
            bus.o_write_data <= '0;
            bus.o_reg_write  <= 1'b0;
            bus.o_wed        <= 1'b0;
            bus.o_Result_Src <= '0;
            bus.o_pc_plus_4  <= '0;
            bus.o_rd         <= '0;
            bus.o_func3      <= '0;
        end else if (bus.flush) begin
            bus.o_alu_result <= '0;
            bus.o_write_data <= '0;
            bus.o_reg_write  <= 1'b0;
            bus.o_wed        <= 1'b0;
            bus.o_Result_Src <= '0;
            bus.o_pc_plus_4  <= '0;
            bus.o_rd         <= '0;
            bus.o_func3      <= '0;
        end else if (!bus.stall) begin
            bus.o_alu_result <= alu;
            bus.o_write_data <= fb;
            bus.o_reg_write  <= bus.in_reg_write;
            bus.o_wed        <= bus.in_wed;
            bus.o_Result_Src <= bus.in_Result_Src;
            bus.o_pc_plus_4  <= bus.in_pc_plus_4;
            bus.o_rd         <= bus.in_rd;
            bus.o_func3      <= bus.in_func3;
        end
    end
endmodule
